// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweep stages: state encoding,
// default vector count and the settle-counter width helper.
package sweep_pkg;

  localparam int unsigned N_VEC = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Settle counter must hold 0..settle and is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle == 0) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Per-vector hold timer: counts up while enabled and flags expiry once
// the count reaches SETTLE; clear restarts it from zero.
module sweep_settle_timer
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = cnt_width(SETTLE);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = (cnt_q == CW'(SETTLE));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a small combinational cell in ascending order,
// samples its output after a settle time and packs the samples into a truth table.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = $clog2(N_VEC),
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 y_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N_IN)-1:0] result
);

  localparam int unsigned NV = 2 ** N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_d;
  logic [NV-1:0]   result_d;
  logic            tmr_clr_c;
  logic            tmr_expire_c;

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_c),
    .en       (state_q == ST_RUN),
    .expire_c (tmr_expire_c)
  );

  // Next state, next vector and result update; vec_out returns to 0 outside RUN.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_out;
    result_d  = result;
    tmr_clr_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start && !abort) begin
          state_d   = ST_RUN;
          result_d  = '0;
          tmr_clr_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d   = ST_IDLE;
          vec_d     = '0;
          tmr_clr_c = 1'b1;
        end else if (tmr_expire_c) begin
          result_d[vec_out] = y_in;
          tmr_clr_c         = 1'b1;
          if (vec_out == VEC_LAST) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_out + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      vec_out   <= vec_d;
      vec_valid <= (state_d == ST_RUN);
      busy      <= (state_d == ST_RUN);
      done      <= (state_d == ST_DONE);
      result    <= result_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: lab cell on a SETTLE=1 instance, y tied high
// on a SETTLE=0 instance; expected tables queued at start, compared at completion.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, start0, abort0;
  logic [3:0]  vec_out, vec_out0;
  logic        vec_valid, busy, done, vec_valid0, busy0, done0;
  logic [15:0] result, result0;
  logic        y;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // Lab cell under test; a = vec_out[3], d = vec_out[0].
  logic a, b, c, d;
  assign {a, b, c, d} = vec_out;
  assign y = !((a & b) | (a & c) | ((c | !c) & (!d | a)));

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y),
    .vec_out(vec_out), .vec_valid(vec_valid), .busy(busy), .done(done), .result(result)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .y_in(1'b1),
    .vec_out(vec_out0), .vec_valid(vec_valid0), .busy(busy0), .done(done0), .result(result0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the SETTLE=1 instance; optional start re-pulses at cycles 3 and 10.
  task automatic sweep_main(input string tag, input bit repulse);
    int n;
    logic [15:0] exp;
    exp_q.push_back(16'h00AA);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_accept_clear"}, 32'(result), 32'd0);
    n = 0;
    while (!done && n < 100) begin
      start = repulse && (n == 3 || n == 10);
      n++;
      tick();
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_result"}, 32'(result), 32'(exp));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] exp;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    #12;
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'({busy, vec_valid, done}), 32'd0);
    rst = 1'b0;
    tick();

    // 1. basic sweep
    sweep_main("t1", 1'b0);

    // 2. y tied high, one cycle per vector
    exp_q.push_back(16'hFFFF);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_vec%0d", i), 32'({vec_valid0, vec_out0}), 32'(16 + i));
      tick();
    end
    check("t2_done", 32'(done0), 32'd1);
    exp = exp_q.pop_front();
    check("t2_result", 32'(result0), 32'(exp));

    // 3. start re-pulses ignored mid-sweep
    sweep_main("t3", 1'b1);

    // 4. abort at vector 5
    exp_q.push_back(16'h000A);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (vec_out != 4'd5 && n < 100) begin
      n++;
      tick();
    end
    check("t4_reach5", 32'(vec_out), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_idle", 32'({busy, vec_valid, done}), 32'd0);
    exp = exp_q.pop_front();
    check("t4_result", 32'(result), 32'(exp));
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n++;
      tick();
    end
    check("t4_no_done", 32'(n), 32'd0);

    // 5. async reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_out", 32'({busy, vec_valid, done, vec_out}), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    #1 rst = 1'b0;
    tick();
    sweep_main("t5", 1'b0);

    // 6. start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    tick();
    check("t6_result", 32'(result), 32'h00AA);
    start = 1'b0; abort = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
